ceu_dma_wr_arb: RTL
===================

// Module: ceu_dma_wr_arb
// PURPOSE
//   Shares the single CEU DMA write-request channel among NUM_REQ outbox writers (local query responder, ICM/context
//   readers, MAD handler). Arbitration is packet-granular round-robin: the grant is held from first beat to last beat.
//   A registered skid stage isolates the requesters from downstream ready timing.
// PARAMETERS
//   NUM_REQ         3                 number of requesters, 2..8
//   DATA_WIDTH      `CEU_DATA_WIDTH   beat width of the data bus
//   DMA_HEAD_WIDTH  128               DMA head width: {rsvd[127:96], addr[95:32], rsvd[31:12], len[11:0]}
// PORTS
//   clk               in   1                      clock
//   rst               in   1                      synchronous, active-high reset
//   req_valid         in   NUM_REQ                per-requester beat valid
//   req_last          in   NUM_REQ                per-requester last beat of packet
//   req_data          in   NUM_REQ*DATA_WIDTH     requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_head          in   NUM_REQ*DMA_HEAD_WIDTH requester i occupies bits [i*DMA_HEAD_WIDTH +: DMA_HEAD_WIDTH]
//   req_ready         out  NUM_REQ                per-requester beat accept
//   dma_wr_req_valid  out  1                      to DMA engine
//   dma_wr_req_last   out  1                      to DMA engine
//   dma_wr_req_data   out  DATA_WIDTH             to DMA engine
//   dma_wr_req_head   out  DMA_HEAD_WIDTH         to DMA engine; forwarded on every beat
//   dma_wr_req_ready  in   1                      from DMA engine
//   busy              out  1                      a packet is locked or the skid stage holds data
//   grant_id          out  $clog2(NUM_REQ)        current or last granted requester
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge) sets: FSM=IDLE, rr_ptr=0, grant_id=0, skid empty, all outputs 0. Reset wins
//     over everything. A packet cut by reset is dropped, and the skid contents are discarded.
//   - FSM IDLE:
//     - If any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
//     - Register it into grant_id and go to LOCK. req_ready stays 0 during the IDLE cycle.
//   - FSM LOCK:
//     - req_ready[grant_id] = skid_in_ready. All other req_ready = 0.
//     - Beat accept = req_valid[g] & req_ready[g]. Data, head and last of requester g are pushed into the skid.
//     - Accepted beat with last=1: go to IDLE and set rr_ptr = (grant_id==NUM_REQ-1) ? 0 : grant_id+1.
//     - If the granted requester deasserts valid mid-packet, stay in LOCK. This inserts bubbles; no re-arbitration.
//   - Latency:
//     - First beat reaches dma_wr_req_valid 2 cycles after req_valid rises (1 cycle arbitration, 1 cycle skid).
//     - Within a packet, throughput is 1 beat/cycle while dma_wr_req_ready=1.
//     - There is exactly 1 idle cycle between consecutive packets (the IDLE arbitration cycle).
//   - Skid stage (2 entries, registered outputs):
//     - skid_in_ready = ~(entry 1 full). Outputs come from entry 0.
//     - Output fields are stable while valid & ~ready. No beat is lost or duplicated when ready toggles every cycle.
//   - Simultaneous events:
//     - Push and pop in the same cycle keep the occupancy unchanged.
//     - A last-beat accept and a new req_valid from another requester in the same cycle: the new request is
//       considered in the next IDLE cycle.
//   - busy = (state==LOCK) | skid non-empty.
//   - A valid from a non-granted requester has no effect. Requesters must hold valid, data, head and last until
//     accepted.
// STRUCTURE
//   - Shared package/header (ceu_def_h.vh): CEU_DATA_WIDTH, DMA head field offsets, and the FSM state encodings
//     ARB_IDLE=2'b01 and ARB_LOCK=2'b10 (one-hot).
//   - One sub-module, ceu_wr_skid: generic 2-entry valid/ready register slice of width DATA_WIDTH+DMA_HEAD_WIDTH+1.
//     It is reusable on the read-response path.
//   - Top level contains the round-robin search (combinational priority over the rotated valid vector), FSM, rr_ptr
//     and the mux.
// TESTING
//   1. Single packet:
//      - Stimulus: req 1 sends 2 beats, head len=12'h100, addr=64'h1000, ready=1.
//      - Response: out valid at cycles t+2 and t+3, last only on the 2nd beat, head equal on both beats, grant_id=1.
//   2. Round-robin fairness:
//      - Stimulus: all 3 requesters continuously valid with 1-beat packets.
//      - Response: grant order 0,1,2,0,1,2. Each out beat is separated by 1 idle cycle.
//   3. Backpressure:
//      - Stimulus: dma_wr_req_ready = 1,0,1,0,... during a 4-beat packet from req 2.
//      - Response: 4 beats out in order, data stable while stalled, no duplicates.
//      - Response: req_ready[2] falls once the skid holds 2 entries.
//   4. Lock hold:
//      - Stimulus: req 0 sends beat 1, drops valid for 3 cycles, then sends its last beat; req 1 is valid throughout.
//      - Response: req 1 gets no ready until req 0's last beat is accepted; the next grant_id is 1.
//   5. Wrap and priority:
//      - Stimulus: NUM_REQ=3, rr_ptr=2, req_valid=3'b011.
//      - Response: grant 0 (wrap), then rr_ptr=1.
//   6. Reset mid-packet:
//      - Stimulus: rst=1 for 1 cycle during beat 2 of a 3-beat packet.
//      - Response: next cycle all outputs 0, busy=0. A fresh request is granted from rr_ptr=0.

Source files
------------

// File: rtl/ceu_dma_wr_arb_pkg.sv
// Shared definitions for the CEU DMA write-request arbiter: bus widths, DMA head
// field layout and the one-hot arbiter state encoding.
package ceu_dma_wr_arb_pkg;

  localparam int CEU_DATA_WIDTH     = 64;
  localparam int CEU_DMA_HEAD_WIDTH = 128;

  // DMA head layout: {rsvd[127:96], addr[95:32], rsvd[31:12], len[11:0]}
  localparam int DMA_HEAD_LEN_LSB  = 0;
  localparam int DMA_HEAD_LEN_W    = 12;
  localparam int DMA_HEAD_ADDR_LSB = 32;
  localparam int DMA_HEAD_ADDR_W   = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b01,
    ARB_LOCK = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ceu_wr_skid.sv
// Generic 2-entry valid/ready register slice. Entry 0 drives the outputs directly
// from flops; entry 1 absorbs the beat that arrives while the output is stalled.
module ceu_wr_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [WIDTH-1:0] data0_reg;
  logic [WIDTH-1:0] data1_reg;
  logic             valid0_reg;
  logic             valid1_reg;
  logic             push;
  logic             pop;

  assign in_ready  = ~valid1_reg;
  assign push      = in_valid & ~valid1_reg;
  assign pop       = valid0_reg & out_ready;
  assign out_valid = valid0_reg;
  assign out_data  = data0_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_reg <= 1'b0;
      valid1_reg <= 1'b0;
      data0_reg  <= '0;
      data1_reg  <= '0;
    end else if (valid1_reg) begin
      // Full: input is blocked, so the only possible event is a pop.
      if (pop) begin
        data0_reg  <= data1_reg;
        valid1_reg <= 1'b0;
      end
    end else if (valid0_reg) begin
      if (push && pop) begin
        data0_reg <= in_data;
      end else if (push) begin
        data1_reg  <= in_data;
        valid1_reg <= 1'b1;
      end else if (pop) begin
        valid0_reg <= 1'b0;
      end
    end else if (push) begin
      data0_reg  <= in_data;
      valid0_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/ceu_dma_wr_arb.sv
// Packet-granular round-robin arbiter sharing the CEU DMA write-request channel
// among NUM_REQ outbox writers, with a registered skid stage toward the DMA engine.
module ceu_dma_wr_arb
  import ceu_dma_wr_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = CEU_DATA_WIDTH,
  parameter int DMA_HEAD_WIDTH = CEU_DMA_HEAD_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ*DMA_HEAD_WIDTH-1:0] req_head,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              dma_wr_req_valid,
  output logic                              dma_wr_req_last,
  output logic [DATA_WIDTH-1:0]             dma_wr_req_data,
  output logic [DMA_HEAD_WIDTH-1:0]         dma_wr_req_head,
  input  logic                              dma_wr_req_ready,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int SUM_W  = ID_W + 1;
  localparam int SKID_W = DATA_WIDTH + DMA_HEAD_WIDTH + 1;

  arb_state_e state_reg, state_next;
  logic [ID_W-1:0] grant_reg, grant_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;

  logic [NUM_REQ-1:0]        rot_valid;
  logic [ID_W-1:0]           rot_idx  [NUM_REQ];
  logic [DATA_WIDTH-1:0]     data_arr [NUM_REQ];
  logic [DMA_HEAD_WIDTH-1:0] head_arr [NUM_REQ];

  logic            pick_any;
  logic [ID_W-1:0] pick_id;
  logic            sel_valid;
  logic            sel_last;
  logic            beat_accept;
  logic            skid_in_ready;
  logic            skid_out_valid;
  logic [SKID_W-1:0] skid_in_data;
  logic [SKID_W-1:0] skid_out_data;

  // Position gi of the rotated vector is requester (rr_ptr + gi) mod NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [SUM_W-1:0] sum;
      assign sum          = SUM_W'(rr_ptr_reg) + SUM_W'(gi);
      assign rot_idx[gi]  = (sum >= SUM_W'(NUM_REQ)) ? ID_W'(sum - SUM_W'(NUM_REQ)) : ID_W'(sum);
      assign rot_valid[gi] = req_valid[rot_idx[gi]];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign head_arr[gi] = req_head[gi*DMA_HEAD_WIDTH +: DMA_HEAD_WIDTH];
    end
  endgenerate

  // Lowest set position of the rotated vector is the first requester at or after rr_ptr.
  always_comb begin
    pick_any = 1'b0;
    pick_id  = rot_idx[0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        pick_any = 1'b1;
        pick_id  = rot_idx[k];
      end
    end
  end

  assign sel_valid    = (state_reg == ARB_LOCK) & req_valid[grant_reg];
  assign sel_last     = req_last[grant_reg];
  assign beat_accept  = sel_valid & skid_in_ready;
  assign skid_in_data = {sel_last, head_arr[grant_reg], data_arr[grant_reg]};

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    req_ready   = '0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_next = pick_id;
          state_next = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        req_ready[grant_reg] = skid_in_ready;
        if (beat_accept && sel_last) begin
          state_next  = ARB_IDLE;
          rr_ptr_next = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg + ID_W'(1);
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  ceu_wr_skid #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sel_valid),
    .in_data   (skid_in_data),
    .in_ready  (skid_in_ready),
    .out_valid (skid_out_valid),
    .out_data  (skid_out_data),
    .out_ready (dma_wr_req_ready)
  );

  assign dma_wr_req_valid = skid_out_valid;
  assign dma_wr_req_data  = skid_out_data[DATA_WIDTH-1:0];
  assign dma_wr_req_head  = skid_out_data[DATA_WIDTH +: DMA_HEAD_WIDTH];
  assign dma_wr_req_last  = skid_out_data[SKID_W-1];
  assign busy             = (state_reg == ARB_LOCK) | skid_out_valid;
  assign grant_id         = grant_reg;

endmodule
